// File: rtl/vector_floating_point_minmax_reduction_unit_if.sv
// Handshake bundle for the FP min/max reduction unit: command capture, operand beat stream and scalar result.
// The master side drives start/operands/result_ready; the slave side is the reduction unit.
interface vector_floating_point_minmax_reduction_unit_if #(
  parameter int LENGTH_WIDTH = 8
);
  logic                    start;
  logic                    maximum_mode;
  logic                    bit_mode;
  logic [LENGTH_WIDTH-1:0] beat_count;
  logic [63:0]             seed;
  logic                    operand_valid;
  logic                    operand_ready;
  logic [63:0]             operand;
  logic                    result_valid;
  logic                    result_ready;
  logic [63:0]             result;
  logic                    busy;

  modport master (
    output start, maximum_mode, bit_mode, beat_count, seed,
    output operand_valid, operand, result_ready,
    input  operand_ready, result_valid, result, busy
  );

  modport slave (
    input  start, maximum_mode, bit_mode, beat_count, seed,
    input  operand_valid, operand, result_ready,
    output operand_ready, result_valid, result, busy
  );
endinterface

// File: rtl/vector_floating_point_minmax_reduction_unit.sv
// Folds a stream of 64-bit beats (one double or two floats) into a scalar using RISC-V vfmax/vfmin rules.
// Latency: start + one edge per accepted beat + one COMBINE cycle; operand_valid low stalls, result held until result_ready.
module vector_floating_point_minmax_reduction_unit #(
  parameter int LENGTH_WIDTH = 8
) (
  input  logic clock,
  input  logic reset,
  vector_floating_point_minmax_reduction_unit_if.slave bus
);
  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] ACCUMULATE = 2'd1;
  localparam logic [1:0] COMBINE    = 2'd2;
  localparam logic [1:0] DONE       = 2'd3;

  localparam logic [31:0] CNAN32 = 32'h7FC0_0000;
  localparam logic [63:0] CNAN64 = 64'h7FF8_0000_0000_0000;
  localparam logic [LENGTH_WIDTH-1:0] ONE = {{(LENGTH_WIDTH-1){1'b0}}, 1'b1};

  // Mapping sign-magnitude to an unsigned key gives a total order with -0.0 < +0.0.
  function automatic logic [31:0] fp32_op(input logic [31:0] a, input logic [31:0] b, input logic is_max);
    logic a_nan, b_nan, a_lt_b;
    logic [31:0] ka, kb;
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    ka     = a[31] ? ~a : {1'b1, a[30:0]};
    kb     = b[31] ? ~b : {1'b1, b[30:0]};
    a_lt_b = ka < kb;
    if (a_nan && b_nan) return CNAN32;
    else if (a_nan)     return b;
    else if (b_nan)     return a;
    else if (is_max)    return a_lt_b ? b : a;
    else                return a_lt_b ? a : b;
  endfunction

  function automatic logic [63:0] fp64_op(input logic [63:0] a, input logic [63:0] b, input logic is_max);
    logic a_nan, b_nan, a_lt_b;
    logic [63:0] ka, kb;
    a_nan  = (a[62:52] == 11'h7FF) && (a[51:0] != 52'd0);
    b_nan  = (b[62:52] == 11'h7FF) && (b[51:0] != 52'd0);
    ka     = a[63] ? ~a : {1'b1, a[62:0]};
    kb     = b[63] ? ~b : {1'b1, b[62:0]};
    a_lt_b = ka < kb;
    if (a_nan && b_nan) return CNAN64;
    else if (a_nan)     return b;
    else if (b_nan)     return a;
    else if (is_max)    return a_lt_b ? b : a;
    else                return a_lt_b ? a : b;
  endfunction

  logic [1:0]              state_q, state_d;
  logic                    max_q, max_d;
  logic                    dbl_q, dbl_d;
  logic [LENGTH_WIDTH-1:0] len_q, len_d;
  logic [LENGTH_WIDTH-1:0] count_q, count_d;
  logic [63:0]             lane0_q, lane0_d;
  logic [31:0]             lane1_q, lane1_d;
  logic [63:0]             result_q, result_d;

  always_comb begin
    state_d  = state_q;
    max_d    = max_q;
    dbl_d    = dbl_q;
    len_d    = len_q;
    count_d  = count_q;
    lane0_d  = lane0_q;
    lane1_d  = lane1_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          max_d   = bus.maximum_mode;
          dbl_d   = bus.bit_mode;
          len_d   = bus.beat_count;
          count_d = '0;
          lane0_d = bus.seed;
          lane1_d = CNAN32;
          state_d = (bus.beat_count == '0) ? COMBINE : ACCUMULATE;
        end
      end
      ACCUMULATE: begin
        if (bus.operand_valid) begin
          if (dbl_q) begin
            lane0_d = fp64_op(lane0_q, bus.operand, max_q);
          end else begin
            lane0_d = {lane0_q[63:32], fp32_op(lane0_q[31:0], bus.operand[31:0], max_q)};
            lane1_d = fp32_op(lane1_q, bus.operand[63:32], max_q);
          end
          count_d = count_q + ONE;
          if (count_q == len_q - ONE) state_d = COMBINE;
        end
      end
      COMBINE: begin
        result_d = dbl_q ? lane0_q : {32'hFFFF_FFFF, fp32_op(lane0_q[31:0], lane1_q, max_q)};
        state_d  = DONE;
      end
      DONE: begin
        if (bus.result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      max_q    <= 1'b0;
      dbl_q    <= 1'b0;
      len_q    <= '0;
      count_q  <= '0;
      lane0_q  <= '0;
      lane1_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      max_q    <= max_d;
      dbl_q    <= dbl_d;
      len_q    <= len_d;
      count_q  <= count_d;
      lane0_q  <= lane0_d;
      lane1_q  <= lane1_d;
      result_q <= result_d;
    end
  end

  assign bus.operand_ready = (state_q == ACCUMULATE);
  assign bus.result_valid  = (state_q == DONE);
  assign bus.busy          = (state_q != IDLE);
  assign bus.result        = result_q;
endmodule

// File: tb/tb_vector_floating_point_minmax_reduction_unit.sv
// Directed and random reductions against a real-valued reference model of vfmax/vfmin.
module tb_vector_floating_point_minmax_reduction_unit;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [63:0] beat_mem [0:15];

  always #5 clock = ~clock;

  vector_floating_point_minmax_reduction_unit_if #(.LENGTH_WIDTH(8)) bus ();

  vector_floating_point_minmax_reduction_unit #(.LENGTH_WIDTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic real f32_real(input logic [31:0] x);
    int  e;
    real m, v;
    e = int'(x[30:23]);
    m = real'(x[22:0]);
    if (e == 255)    v = 1.0e300;
    else if (e == 0) v = m * (2.0 ** (-149.0));
    else             v = (m + 8388608.0) * (2.0 ** real'(e - 150));
    return x[31] ? -v : v;
  endfunction

  function automatic bit take_b(input real va, input real vb, input bit sa, input bit sb, input bit mx);
    if (va == vb) return mx ? (sa && !sb) : (!sa && sb);
    return mx ? (va < vb) : (vb < va);
  endfunction

  function automatic logic [31:0] ref32(input logic [31:0] a, input logic [31:0] b, input bit mx);
    bit an, bn;
    an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    if (an && bn) return 32'h7FC0_0000;
    if (an) return b;
    if (bn) return a;
    return take_b(f32_real(a), f32_real(b), a[31], b[31], mx) ? b : a;
  endfunction

  function automatic logic [63:0] ref64(input logic [63:0] a, input logic [63:0] b, input bit mx);
    bit an, bn;
    an = (a[62:52] == 11'h7FF) && (a[51:0] != 0);
    bn = (b[62:52] == 11'h7FF) && (b[51:0] != 0);
    if (an && bn) return 64'h7FF8_0000_0000_0000;
    if (an) return b;
    if (bn) return a;
    return take_b($bitstoreal(a), $bitstoreal(b), a[63], b[63], mx) ? b : a;
  endfunction

  function automatic logic [63:0] ref_reduce(input bit mx, input bit db, input logic [63:0] sd, input int n);
    logic [63:0] acc;
    logic [31:0] lo, hi;
    acc = sd;
    lo  = sd[31:0];
    hi  = 32'h7FC0_0000;
    for (int i = 0; i < n; i++) begin
      acc = ref64(acc, beat_mem[i], mx);
      lo  = ref32(lo, beat_mem[i][31:0], mx);
      hi  = ref32(hi, beat_mem[i][63:32], mx);
    end
    return db ? acc : {32'hFFFF_FFFF, ref32(lo, hi, mx)};
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h7FC0_0000;
      3: return 32'h7F80_0001;
      4: return 32'hFF80_0000;
      5: return $urandom & 32'hC0FF_0000;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 7))
      0: return 64'h0;
      1: return 64'h8000_0000_0000_0000;
      2: return 64'h7FF8_0000_0000_0000;
      3: return 64'h7FF0_0000_0000_0001;
      4: return 64'hFFF0_0000_0000_0000;
      5: return {$urandom & 32'hC00F_0000, 32'h0};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // ---------------- one reduction ----------------
  task automatic do_run(input string tag, input bit mx, input bit db, input logic [63:0] sd,
                        input int n, input bit stall, input int hold);
    logic [63:0] exp;
    int cyc, idx, guard;
    exp = ref_reduce(mx, db, sd, n);
    @(negedge clock);
    bus.start        = 1'b1;
    bus.maximum_mode = mx;
    bus.bit_mode     = db;
    bus.beat_count   = 8'(n);
    bus.seed         = sd;
    @(negedge clock);
    cyc = 1;
    bus.start        = 1'b0;
    bus.maximum_mode = ~mx;
    bus.bit_mode     = ~db;
    bus.beat_count   = 8'($urandom);
    bus.seed         = {$urandom, $urandom};
    check({tag, "_busy"}, 64'(bus.busy), 64'd1);
    idx = 0;
    while (idx < n && cyc < 200) begin
      bus.operand_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.operand       = bus.operand_valid ? beat_mem[idx] : {$urandom, $urandom};
      bus.start         = stall ? 1'($urandom_range(0, 1)) : 1'b0;
      check({tag, "_oprdy"}, 64'(bus.operand_ready), 64'd1);
      @(negedge clock);
      cyc++;
      if (bus.operand_valid) idx++;
    end
    bus.operand_valid = 1'b0;
    bus.start         = 1'b0;
    guard = 0;
    while (!bus.result_valid && guard < 10) begin
      @(negedge clock);
      cyc++;
      guard++;
    end
    check({tag, "_valid"}, 64'(bus.result_valid), 64'd1);
    check({tag, "_result"}, bus.result, exp);
    check({tag, "_latency"}, 64'(cyc), 64'(cyc - guard + 1));
    check({tag, "_cycles"}, 64'(cyc), 64'(idx + (cyc - guard - 1 - idx) + 2));
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check({tag, "_hold_valid"}, 64'(bus.result_valid), 64'd1);
      check({tag, "_hold_result"}, bus.result, exp);
    end
    bus.result_ready = 1'b1;
    bus.start        = 1'b1;
    @(negedge clock);
    bus.result_ready = 1'b0;
    bus.start        = 1'b0;
    check({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_idle_valid"}, 64'(bus.result_valid), 64'd0);
  endtask

  // Expected latency = 2 + every cycle spent in ACCUMULATE (beats + stalls), supplied by the caller.
  task automatic do_run_lat(input string tag, input bit mx, input bit db, input logic [63:0] sd,
                            input int n, input int exp_cycles);
    logic [63:0] exp;
    int cyc, guard;
    exp = ref_reduce(mx, db, sd, n);
    @(negedge clock);
    bus.start = 1'b1; bus.maximum_mode = mx; bus.bit_mode = db;
    bus.beat_count = 8'(n); bus.seed = sd;
    @(negedge clock);
    bus.start = 1'b0;
    cyc = 1;
    for (int i = 0; i < n; i++) begin
      bus.operand_valid = 1'b1;
      bus.operand       = beat_mem[i];
      @(negedge clock);
      cyc++;
    end
    bus.operand_valid = 1'b0;
    guard = 0;
    while (!bus.result_valid && guard < 10) begin
      @(negedge clock);
      cyc++;
      guard++;
    end
    check({tag, "_result"}, bus.result, exp);
    check({tag, "_latency"}, 64'(cyc), 64'(exp_cycles));
    bus.result_ready = 1'b1;
    @(negedge clock);
    bus.result_ready = 1'b0;
    check({tag, "_idle"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    bit seen;
    bus.start = 1'b0; bus.maximum_mode = 1'b0; bus.bit_mode = 1'b0;
    bus.beat_count = '0; bus.seed = '0; bus.operand_valid = 1'b0;
    bus.operand = '0; bus.result_ready = 1'b0;
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_oprdy", 64'(bus.operand_ready), 64'd0);
    check("rst_valid", 64'(bus.result_valid), 64'd0);
    check("rst_result", bus.result, 64'd0);
    @(negedge clock);
    reset = 1'b0;

    beat_mem[0] = 64'h4008_0000_0000_0000;
    beat_mem[1] = 64'hC014_0000_0000_0000;
    do_run_lat("max64", 1'b1, 1'b1, 64'h3FF0_0000_0000_0000, 2, 4);
    check("max64_exact", bus.result, 64'h4008_0000_0000_0000);

    beat_mem[0] = 64'h3F00_0000_BF80_0000;
    beat_mem[1] = 64'hC040_0000_4080_0000;
    do_run("min32", 1'b0, 1'b0, 64'h0000_0000_4000_0000, 2, 1'b0, 0);
    check("min32_exact", bus.result, 64'hFFFF_FFFF_C040_0000);

    beat_mem[0] = 64'h0000_0000_7F80_0001;
    do_run("nan_one", 1'b1, 1'b0, 64'h0000_0000_7FC0_0000, 1, 1'b0, 0);
    check("nan_one_exact", bus.result, 64'hFFFF_FFFF_0000_0000);

    beat_mem[0] = 64'h7FC0_0001_7F80_0001;
    do_run("nan_all", 1'b1, 1'b0, 64'h0000_0000_7F80_0005, 1, 1'b0, 0);
    check("nan_all_exact", bus.result, 64'hFFFF_FFFF_7FC0_0000);

    beat_mem[0] = 64'h8000_0000_0000_0000;
    do_run("negzero", 1'b0, 1'b1, 64'h0, 1, 1'b0, 0);
    check("negzero_exact", bus.result, 64'h8000_0000_0000_0000);

    do_run_lat("empty", 1'b1, 1'b1, 64'h1234_5678_9ABC_DEF0, 0, 2);
    check("empty_exact", bus.result, 64'h1234_5678_9ABC_DEF0);

    for (int i = 0; i < 5; i++) beat_mem[i] = {rnd32(), rnd32()};
    do_run("stall_hold", 1'b1, 1'b0, {32'h0, rnd32()}, 5, 1'b1, 5);

    // Abort mid-accumulate: busy must drop at once and no result may appear.
    @(negedge clock);
    bus.start = 1'b1; bus.maximum_mode = 1'b1; bus.bit_mode = 1'b1;
    bus.beat_count = 8'd4; bus.seed = 64'h3FF0_0000_0000_0000;
    @(negedge clock);
    bus.start = 1'b0;
    bus.operand_valid = 1'b1; bus.operand = 64'h4008_0000_0000_0000;
    @(negedge clock);
    check("abort_pre_busy", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_oprdy", 64'(bus.operand_ready), 64'd0);
    check("abort_result", bus.result, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (bus.result_valid || bus.busy) seen = 1'b1;
    end
    bus.operand_valid = 1'b0;
    check("abort_no_result", 64'(seen), 64'd0);

    beat_mem[0] = 64'h4008_0000_0000_0000;
    beat_mem[1] = 64'hC014_0000_0000_0000;
    do_run_lat("after_abort", 1'b1, 1'b1, 64'h3FF0_0000_0000_0000, 2, 4);

    for (int r = 0; r < 40; r++) begin
      bit mx, db, st;
      int n;
      logic [63:0] sd;
      mx = 1'($urandom_range(0, 1));
      db = 1'($urandom_range(0, 1));
      st = 1'($urandom_range(0, 1));
      n  = $urandom_range(0, 6);
      sd = db ? rnd64() : {$urandom, rnd32()};
      for (int i = 0; i < n; i++) beat_mem[i] = db ? rnd64() : {rnd32(), rnd32()};
      do_run($sformatf("rnd%0d", r), mx, db, sd, n, st, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/vector_floating_point_minmax_reduction_unit.md
VECTOR_FLOATING_POINT_MINMAX_REDUCTION_UNIT -- requirements
Module: vector_floating_point_minmax_reduction_unit

Interface
REQ-001 The block SHALL have parameter LENGTH_WIDTH, default 8, giving the width of the beat-count input.
REQ-002 The block SHALL have one clock and asynchronous active-high reset: port clock, input, 1, sole clock, rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, which begins a reduction when sampled in IDLE.
REQ-005 The block SHALL have port maximum_mode, input, 1, where 1 selects maximum and 0 selects minimum; it is captured at start.
REQ-006 The block SHALL have port bit_mode, input, 1, where 1 selects 64-bit doubles and 0 selects two 32-bit floats per beat; it is captured at start.
REQ-007 The block SHALL have port beat_count, input, LENGTH_WIDTH, giving the number of 64-bit operand beats; it is captured at start.
REQ-008 The block SHALL have port seed, input, 64, holding the initial scalar (low 32 bits in 32-bit mode); it is captured at start.
REQ-009 The block SHALL have ports operand_valid (input, 1), operand_ready (output, 1) and operand (input, 64) forming the operand beat handshake.
REQ-010 The block SHALL have ports result_valid (output, 1), result_ready (input, 1) and result (output, 64) forming the scalar result handshake.
REQ-011 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-012 The state machine SHALL have exactly the states IDLE, ACCUMULATE, COMBINE and DONE.
REQ-013 In IDLE with start=1, the block SHALL capture its mode, count and seed and SHALL move to ACCUMULATE, or directly to COMBINE if beat_count=0.
REQ-014 On start, the block SHALL load the seed into accumulator lane 0 and SHALL load lane 1 with a canonical NaN.
REQ-015 operand_ready SHALL be 1 only in ACCUMULATE.
REQ-016 A beat SHALL transfer on a rising edge where operand_valid and operand_ready are both 1.
REQ-017 Each transferred beat SHALL update the accumulators on the same edge.
- 64-bit mode: lane 0 = op(lane 0, operand[63:0]).
- 32-bit mode: lane 0 = op(lane 0, operand[31:0]) and lane 1 = op(lane 1, operand[63:32]).
REQ-018 The block SHALL count transferred beats and SHALL move to COMBINE on the edge that accepts beat number beat_count; ACCUMULATE SHALL hold with no update while operand_valid=0.
REQ-019 COMBINE SHALL last exactly one cycle.
- 32-bit mode: the final value is op(lane 0, lane 1).
- 64-bit mode: the final value is lane 0.
- The block then moves to DONE.
REQ-020 result_valid SHALL be 1 only in DONE, and result SHALL stay stable until the cycle in which result_ready=1, after which the block returns to IDLE.
REQ-021 In 32-bit mode, result[63:32] SHALL be 0xFFFFFFFF (NaN-boxed).
REQ-022 Operation op SHALL implement RISC-V vfmax/vfmin semantics.
- The ordering SHALL use sign and magnitude, with -0.0 < +0.0.
- If exactly one operand is NaN, the other operand SHALL be returned.
- If both operands are NaN, the canonical NaN SHALL be returned: 0x7FC00000 for 32-bit, 0x7FF8000000000000 for 64-bit.
- Both quiet and signalling NaNs SHALL be treated as NaN; no exception flags are required.
REQ-023 start SHALL be ignored outside IDLE, including in the DONE handshake cycle.
REQ-024 operand inputs SHALL be ignored outside ACCUMULATE.
REQ-025 Minimum latency SHALL be start edge + beat_count accepted-beat edges + 1 COMBINE cycle, after which result_valid is asserted.

Reset
REQ-026 While reset=1, asynchronously:
- the state SHALL be IDLE;
- operand_ready, result_valid and busy SHALL be 0;
- result, the accumulators, the beat counter and the captured mode registers SHALL be 0.
REQ-027 A reset asserted during ACCUMULATE, COMBINE or DONE SHALL abort the reduction with no result produced, and the next start after release SHALL behave as if from power-up.

Verification
REQ-028 Max in 64-bit mode: seed=1.0 (0x3FF0000000000000), beats 3.0 and -5.0, with back-to-back valid -> result 0x4008000000000000 exactly 4 cycles after start.
REQ-029 Min in 32-bit mode: seed=2.0, beats {lo=-1.0, hi=0.5} and {lo=4.0, hi=-3.0} -> result 0xFFFFFFFF_C0400000 (-3.0).
REQ-030 NaN handling:
- Max in 32-bit mode with seed=qNaN and beat {lo=sNaN 0x7F800001, hi=+0.0} -> result 0xFFFFFFFF_00000000.
- With all inputs NaN -> result 0xFFFFFFFF_7FC00000.
REQ-031 Signed zero and empty input:
- Min in 64-bit mode with seed=+0.0 and beat -0.0 -> result 0x8000000000000000.
- With beat_count=0 -> result equals seed, with result_valid asserted 2 cycles after start.
REQ-032 Handshake and reset behaviour:
- Toggling operand_valid stalls the accumulators with no update.
- Holding result_ready=0 for 5 cycles keeps the result stable.
- Asserting reset mid-ACCUMULATE forces busy=0 immediately, and no result_valid follows.
